// File: rtl/pipe_decode_ctrl_if.sv
// Bundle between the IF/ID stage, the decode control unit and the ID/EX control register.
// Carries the decode inputs, the hazard/stall side-band and the registered control word.
interface pipe_decode_ctrl_if #(
  parameter int OP_W = 4,
  parameter int FN_W = 4,
  parameter int RA_W = 4
);
  // instr_valid qualifies op/funct/id_rs/id_rt in IF/ID; out_valid qualifies the ID/EX word.
  // There is no ready: stall holds ID/EX, hazard_stall bubbles ID/EX and asks IF/ID to hold.
  logic            instr_valid;
  logic [OP_W-1:0] op;
  logic [FN_W-1:0] funct;
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic            ex_is_load;
  logic [RA_W-1:0] ex_rd;
  logic            stall;
  logic            flush;

  logic            hazard_stall;
  logic            illegal_op;
  logic            out_valid;
  logic            alu_op;
  logic            alu_src;
  logic            reg_wr1_n;
  logic            reg_wr2_n;
  logic            wr2_add_mux;
  logic            mem_to_reg;
  logic            mem_wr_n;
  logic            byte_op_n;
  logic            halt_n;
  logic [1:0]      instr_type;
  logic [3:0]      alu_func;
  logic [1:0]      branch_mode;
  logic            halted;
  logic [1:0]      fsm_state;  // 0 run, 1 drain, 2 halted

  modport master (
    output instr_valid, op, funct, id_rs, id_rt, ex_is_load, ex_rd, stall, flush,
    input  hazard_stall, illegal_op, out_valid, alu_op, alu_src, reg_wr1_n, reg_wr2_n,
           wr2_add_mux, mem_to_reg, mem_wr_n, byte_op_n, halt_n, instr_type, alu_func,
           branch_mode, halted, fsm_state
  );

  modport slave (
    input  instr_valid, op, funct, id_rs, id_rt, ex_is_load, ex_rd, stall, flush,
    output hazard_stall, illegal_op, out_valid, alu_op, alu_src, reg_wr1_n, reg_wr2_n,
           wr2_add_mux, mem_to_reg, mem_wr_n, byte_op_n, halt_n, instr_type, alu_func,
           branch_mode, halted, fsm_state
  );
endinterface

// File: rtl/pipe_decode_ctrl.sv
// Registered decode control: decodes IF/ID into the ID/EX control word, handles stall/flush,
// load-use hazards and a halt-drain sequence that bubbles the pipe before stopping it.
module pipe_decode_ctrl #(
  parameter int OP_W         = 4,
  parameter int FN_W         = 4,
  parameter int RA_W         = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int BYTE_OPS_EN  = 1
) (
  input logic               clk,
  input logic               rst,
  pipe_decode_ctrl_if.slave bus
);

  typedef struct packed {
    logic       out_valid;
    logic       illegal_op;
    logic       alu_op;
    logic       alu_src;
    logic       reg_wr1_n;
    logic       reg_wr2_n;
    logic       wr2_add_mux;
    logic       mem_to_reg;
    logic       mem_wr_n;
    logic       byte_op_n;
    logic       halt_n;
    logic [1:0] instr_type;
    logic [3:0] alu_func;
    logic [1:0] branch_mode;
  } ctrl_t;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam ctrl_t BUBBLE = '{out_valid: 1'b0, illegal_op: 1'b0, alu_op: 1'b1, alu_src: 1'b1,
                               reg_wr1_n: 1'b1, reg_wr2_n: 1'b1, wr2_add_mux: 1'b0,
                               mem_to_reg: 1'b1, mem_wr_n: 1'b1, byte_op_n: 1'b1, halt_n: 1'b1,
                               instr_type: 2'b11, alu_func: 4'b0000, branch_mode: 2'b11};

  state_t          state, state_d;
  logic [3:0]      cnt, cnt_d;
  ctrl_t           ctrl_q, ctrl_d, dec;
  logic            halted_q;
  logic            bad_op, byte_off, op_hi_bad, hazard, load_halt;
  logic [OP_W-1:0] op_full;
  logic [FN_W-1:0] fn_full;
  logic [RA_W-1:0] rs, rt, rd;
  logic [3:0]      op4, fn4;

  assign op_full   = bus.op;
  assign fn_full   = bus.funct;
  assign op4       = op_full[3:0];
  assign fn4       = fn_full[3:0];
  assign op_hi_bad = (op_full >> 4) != '0;
  assign byte_off  = (BYTE_OPS_EN == 0) && ((op4 == 4'b1010) || (op4 == 4'b1011));
  assign rs        = bus.id_rs;
  assign rt        = bus.id_rt;
  assign rd        = bus.ex_rd;

  // Load-use compare is only meaningful while the pipe is still running.
  assign hazard = (state == S_RUN) && bus.ex_is_load && bus.instr_valid && (rd != '0) &&
                  ((rd == rs) || (rd == rt));

  always_comb begin
    dec           = BUBBLE;
    dec.out_valid = 1'b1;
    bad_op        = op_hi_bad;
    case (op4)
      4'b1111: begin
        dec.alu_op      = 1'b0;
        dec.alu_src     = 1'b0;
        dec.instr_type  = 2'b00;
        dec.reg_wr2_n   = (fn4 == 4'b1000) || (fn4 == 4'b0100) || (fn4 == 4'b0101);
        dec.wr2_add_mux = (fn4 == 4'b1000);
        if (fn4 == 4'b1000)      dec.alu_func = 4'b1101;
        else if (fn4 == 4'b0111) dec.alu_func = 4'b1110;
        else                     dec.alu_func = fn4;
      end
      4'b1000, 4'b1001: begin
        dec.reg_wr2_n  = 1'b0;
        dec.alu_op     = 1'b0;
        dec.alu_src    = 1'b1;
        dec.instr_type = 2'b10;
        dec.alu_func   = op4;
      end
      4'b1010, 4'b1011, 4'b1100, 4'b1101: begin
        dec.mem_to_reg = 1'b0;
        dec.alu_op     = 1'b0;
        dec.alu_src    = 1'b0;
        dec.instr_type = 2'b01;
        // op[2] separates word from byte access, op[0] separates store from load.
        if (op4[2]) begin
          dec.alu_func = 4'b1100;
        end else begin
          dec.alu_func  = 4'b1111;
          dec.byte_op_n = 1'b0;
        end
        if (op4[0]) dec.mem_wr_n  = 1'b0;
        else        dec.reg_wr2_n = 1'b0;
      end
      4'b0101: dec.branch_mode = 2'b10;
      4'b0100: dec.branch_mode = 2'b01;
      4'b0110: dec.branch_mode = 2'b00;
      4'b0000: ;
      default: bad_op = 1'b1;
    endcase
    if (bad_op || byte_off) begin
      dec            = BUBBLE;
      dec.out_valid  = 1'b1;
      dec.halt_n     = 1'b0;
      dec.alu_func   = 4'b0001;
      dec.illegal_op = bad_op;
    end
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    load_halt = 1'b0;
    if (state != S_RUN)       ctrl_d = BUBBLE;
    else if (bus.flush)       ctrl_d = BUBBLE;
    else if (bus.stall)       ctrl_d = ctrl_q;
    else if (hazard)          ctrl_d = BUBBLE;
    else if (bus.instr_valid) begin
      ctrl_d    = dec;
      load_halt = !dec.halt_n;
    end else                  ctrl_d = BUBBLE;
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      S_RUN: if (load_halt) begin
        state_d = S_DRAIN;
        cnt_d   = 4'(DRAIN_CYCLES - 1);
      end
      S_DRAIN: begin
        if (cnt == 4'd0) state_d = S_HALTED;
        else             cnt_d   = cnt - 4'd1;
      end
      S_HALTED: ;
      default: state_d = S_RUN;
    endcase
  end

  // halted follows HALTED by one edge so it rises after the last drain bubble is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_RUN;
      cnt      <= 4'd0;
      ctrl_q   <= BUBBLE;
      halted_q <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      ctrl_q   <= ctrl_d;
      halted_q <= (state == S_HALTED);
    end
  end

  assign bus.hazard_stall = hazard;
  assign bus.illegal_op   = ctrl_q.illegal_op;
  assign bus.out_valid    = ctrl_q.out_valid;
  assign bus.alu_op       = ctrl_q.alu_op;
  assign bus.alu_src      = ctrl_q.alu_src;
  assign bus.reg_wr1_n    = ctrl_q.reg_wr1_n;
  assign bus.reg_wr2_n    = ctrl_q.reg_wr2_n;
  assign bus.wr2_add_mux  = ctrl_q.wr2_add_mux;
  assign bus.mem_to_reg   = ctrl_q.mem_to_reg;
  assign bus.mem_wr_n     = ctrl_q.mem_wr_n;
  assign bus.byte_op_n    = ctrl_q.byte_op_n;
  assign bus.halt_n       = ctrl_q.halt_n;
  assign bus.instr_type   = ctrl_q.instr_type;
  assign bus.alu_func     = ctrl_q.alu_func;
  assign bus.branch_mode  = ctrl_q.branch_mode;
  assign bus.halted       = halted_q;
  assign bus.fsm_state    = state;

endmodule

// File: tb/tb_pipe_decode_ctrl.sv
// Bench for pipe_decode_ctrl: directed scenarios plus randomized traffic against a
// cycle-level reference model of decode, priority, hazard and halt-drain behaviour.
module tb_pipe_decode_ctrl;
  localparam int DC = 3;
  // {out_valid, illegal_op, alu_op, alu_src, reg_wr1_n, reg_wr2_n, wr2_add_mux, mem_to_reg,
  //  mem_wr_n, byte_op_n, halt_n, instr_type[1:0], alu_func[3:0], branch_mode[1:0]}
  localparam logic [18:0] BUBBLE = {11'b00111101111, 2'b11, 4'b0000, 2'b11};
  localparam logic [3:0] DEF_OPS [11] = '{4'd0, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9,
                                          4'd10, 4'd11, 4'd12, 4'd13, 4'd15};

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;

  logic [18:0] m_word;
  bit          m_stopped;
  int          m_since;
  logic [18:0] act_word;
  logic [18:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_decode_ctrl_if #(.OP_W(4), .FN_W(4), .RA_W(4)) bus ();
  pipe_decode_ctrl_if #(.OP_W(4), .FN_W(4), .RA_W(4)) bus2 ();

  pipe_decode_ctrl #(.OP_W(4), .FN_W(4), .RA_W(4), .DRAIN_CYCLES(DC), .BYTE_OPS_EN(1)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  pipe_decode_ctrl #(.OP_W(4), .FN_W(4), .RA_W(4), .DRAIN_CYCLES(DC), .BYTE_OPS_EN(0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));

  assign act_word = {bus.out_valid, bus.illegal_op, bus.alu_op, bus.alu_src, bus.reg_wr1_n,
                     bus.reg_wr2_n, bus.wr2_add_mux, bus.mem_to_reg, bus.mem_wr_n,
                     bus.byte_op_n, bus.halt_n, bus.instr_type, bus.alu_func, bus.branch_mode};

  // Reference decode written from the instruction classes rather than bit patterns.
  function automatic logic [18:0] model_decode(input logic [3:0] o, input logic [3:0] f,
                                               input bit byte_en);
    logic ov, ill, aop, asrc, w1, w2, mux, m2r, mw, bo, hn;
    logic [1:0] it, bm;
    logic [3:0] af;
    bit is_load, is_store, is_byte, defined;
    ov = 1; ill = 0; aop = 1; asrc = 1; w1 = 1; w2 = 1; mux = 0; m2r = 1; mw = 1; bo = 1;
    hn = 1; it = 2'b11; af = 4'd0; bm = 2'b11;
    is_load  = (o == 4'd10) || (o == 4'd12);
    is_store = (o == 4'd11) || (o == 4'd13);
    is_byte  = (o == 4'd10) || (o == 4'd11);
    defined  = o inside {4'd0, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd15};
    if (!defined || (is_byte && !byte_en)) begin
      hn = 0; af = 4'd1; ill = !defined;
    end else if (o == 4'd15) begin
      aop = 0; asrc = 0; it = 2'b00;
      mux = (f == 4'd8);
      w2  = (f == 4'd8) || (f == 4'd4) || (f == 4'd5);
      af  = (f == 4'd8) ? 4'd13 : (f == 4'd7) ? 4'd14 : f;
    end else if (o == 4'd8 || o == 4'd9) begin
      w2 = 0; aop = 0; asrc = 1; it = 2'b10; af = (o == 4'd8) ? 4'd8 : 4'd9;
    end else if (is_load || is_store) begin
      m2r = 0; aop = 0; asrc = 0; it = 2'b01;
      if (is_load) w2 = 0; else mw = 0;
      af = is_byte ? 4'd15 : 4'd12;
      bo = !is_byte;
    end else if (o == 4'd5) bm = 2'b10;
    else if (o == 4'd4) bm = 2'b01;
    else if (o == 4'd6) bm = 2'b00;
    return {ov, ill, aop, asrc, w1, w2, mux, m2r, mw, bo, hn, it, af, bm};
  endfunction

  function automatic bit model_hazard();
    return !m_stopped && bus.ex_is_load && bus.instr_valid && (bus.ex_rd != 0) &&
           ((bus.ex_rd == bus.id_rs) || (bus.ex_rd == bus.id_rt));
  endfunction

  function automatic bit model_halted();
    return m_stopped && (m_since >= DC + 1);
  endfunction

  task automatic model_reset();
    m_word = BUBBLE; m_stopped = 0; m_since = 0;
  endtask

  task automatic drive_idle();
    bus.instr_valid = 0; bus.op = 0; bus.funct = 0; bus.id_rs = 0; bus.id_rt = 0;
    bus.ex_is_load = 0; bus.ex_rd = 0; bus.stall = 0; bus.flush = 0;
    bus2.instr_valid = 0; bus2.op = 0; bus2.funct = 0; bus2.id_rs = 0; bus2.id_rt = 0;
    bus2.ex_is_load = 0; bus2.ex_rd = 0; bus2.stall = 0; bus2.flush = 0;
  endtask

  // One clock edge: predict the next ID/EX word from the current inputs, then commit it.
  task automatic advance();
    logic [18:0] nxt;
    bit stop_n;
    int since_n;
    bit hz;
    hz = model_hazard();
    nxt = m_word; stop_n = m_stopped; since_n = m_since;
    if (m_stopped) begin
      nxt = BUBBLE; since_n = m_since + 1;
    end else if (bus.flush) nxt = BUBBLE;
    else if (bus.stall) nxt = m_word;
    else if (hz) nxt = BUBBLE;
    else if (bus.instr_valid) begin
      nxt = model_decode(bus.op, bus.funct, 1'b1);
      if (nxt[8] == 1'b0) begin stop_n = 1; since_n = 0; end
    end else nxt = BUBBLE;
    @(posedge clk); #1;
    m_word = nxt; m_stopped = stop_n; m_since = since_n;
  endtask

  task automatic finish_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; drive_idle(); model_reset();
    #3;
    checks++; if (act_word !== BUBBLE) begin errors++; $display("FAIL reset_word: got %h expected %h", act_word, BUBBLE); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", bus.halted); end
    bus.ex_is_load = 1; bus.instr_valid = 1; bus.ex_rd = 4'd2; bus.id_rs = 4'd2;
    #1;
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL reset_hazard: got %b expected 1", bus.hazard_stall); end
    drive_idle();
    finish_reset();
  endtask

  task automatic test_decode_sweep();
    bus.instr_valid = 1; bus.op = 4'b1111; bus.funct = 4'b1000;
    advance();
    checks++; if (bus.wr2_add_mux !== 1'b1) begin errors++; $display("FAIL r8_mux: got %b expected 1", bus.wr2_add_mux); end
    checks++; if (bus.alu_func !== 4'b1101) begin errors++; $display("FAIL r8_func: got %b expected 1101", bus.alu_func); end
    checks++; if (bus.reg_wr2_n !== 1'b1) begin errors++; $display("FAIL r8_wr2: got %b expected 1", bus.reg_wr2_n); end
    bus.funct = 4'b0111;
    advance();
    checks++; if (bus.alu_func !== 4'b1110) begin errors++; $display("FAIL r7_func: got %b expected 1110", bus.alu_func); end
    checks++; if (bus.reg_wr2_n !== 1'b0) begin errors++; $display("FAIL r7_wr2: got %b expected 0", bus.reg_wr2_n); end
    bus.op = 4'b1100; bus.funct = 4'd0;
    #1;
    checks++; if (bus.alu_func !== 4'b1110) begin errors++; $display("FAIL decode_latency: got %b expected 1110", bus.alu_func); end
    advance();
    checks++; if (bus.mem_to_reg !== 1'b0 || bus.alu_func !== 4'b1100 || bus.byte_op_n !== 1'b1)
      begin errors++; $display("FAIL lw_word: got m2r=%b func=%b bo=%b expected 0 1100 1", bus.mem_to_reg, bus.alu_func, bus.byte_op_n); end
    bus.op = 4'b1011;
    advance();
    checks++; if (bus.mem_wr_n !== 1'b0 || bus.byte_op_n !== 1'b0)
      begin errors++; $display("FAIL sb_word: got mw=%b bo=%b expected 0 0", bus.mem_wr_n, bus.byte_op_n); end
    checks++; if (act_word !== m_word) begin errors++; $display("FAIL sb_full: got %h expected %h", act_word, m_word); end
    drive_idle();
    advance();
  endtask

  task automatic test_load_use();
    bus.instr_valid = 1; bus.op = 4'b1100; bus.ex_is_load = 1; bus.ex_rd = 4'd3;
    bus.id_rt = 4'd3; bus.id_rs = 4'd1;
    #1;
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL hazard_rt: got %b expected 1", bus.hazard_stall); end
    advance();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hazard_bubble: got %b expected 0", bus.out_valid); end
    bus.ex_rd = 4'd0; bus.id_rt = 4'd0;
    #1;
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL hazard_r0: got %b expected 0", bus.hazard_stall); end
    advance();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL no_hazard_valid: got %b expected 1", bus.out_valid); end
    bus.ex_rd = 4'd5; bus.id_rs = 4'd5;
    #1;
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL hazard_rs: got %b expected 1", bus.hazard_stall); end
    drive_idle();
    advance();
  endtask

  task automatic test_stall_flush();
    bus.instr_valid = 1; bus.op = 4'b1000;
    advance();
    checks++; if (bus.alu_func !== 4'b1000 || bus.alu_src !== 1'b1 || bus.instr_type !== 2'b10)
      begin errors++; $display("FAIL andi_word: got func=%b src=%b type=%b", bus.alu_func, bus.alu_src, bus.instr_type); end
    bus.stall = 1; bus.op = 4'b1100;
    for (int i = 0; i < 2; i++) begin
      advance();
      checks++; if (bus.alu_func !== 4'b1000 || act_word !== m_word)
        begin errors++; $display("FAIL stall_hold%0d: got %h expected %h", i, act_word, m_word); end
    end
    bus.flush = 1;
    advance();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_over_stall: got %b expected 0", bus.out_valid); end
    drive_idle();
    advance();
  endtask

  task automatic test_halt_drain();
    bus.instr_valid = 1; bus.op = 4'b0011;
    advance();
    checks++; if (bus.halt_n !== 1'b0 || bus.illegal_op !== 1'b1 || bus.alu_func !== 4'b0001 || bus.out_valid !== 1'b1)
      begin errors++; $display("FAIL halt_word: got %h expected %h", act_word, m_word); end
    bus.op = 4'b1100; bus.ex_is_load = 1; bus.ex_rd = 4'd3; bus.id_rs = 4'd3;
    for (int i = 0; i < DC; i++) begin
      #1;
      checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL drain_hazard_gate%0d: got %b expected 0", i, bus.hazard_stall); end
      advance();
      checks++; if (act_word !== BUBBLE || bus.halted !== 1'b0)
        begin errors++; $display("FAIL drain_bubble%0d: got %h halted=%b expected %h halted=0", i, act_word, bus.halted, BUBBLE); end
    end
    advance();
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halted_rise: got %b expected 1", bus.halted); end
    advance();
    checks++; if (act_word !== BUBBLE || bus.halted !== 1'b1)
      begin errors++; $display("FAIL halted_hold: got %h halted=%b expected %h halted=1", act_word, bus.halted, BUBBLE); end
    #2; rst = 1; #1; model_reset();
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halted_async_clear: got %b expected 0", bus.halted); end
    drive_idle();
    finish_reset();
  endtask

  task automatic test_byte_disabled();
    bus2.instr_valid = 1; bus2.op = 4'b1010;
    advance();
    checks++; if (bus2.halt_n !== 1'b0 || bus2.illegal_op !== 1'b0 || bus2.out_valid !== 1'b1)
      begin errors++; $display("FAIL lb_disabled: got halt_n=%b ill=%b ov=%b expected 0 0 1", bus2.halt_n, bus2.illegal_op, bus2.out_valid); end
    checks++; if (bus2.fsm_state !== 2'd1) begin errors++; $display("FAIL lb_disabled_drain: got %0d expected 1", bus2.fsm_state); end
    drive_idle();
    advance();
    checks++; if (bus2.out_valid !== 1'b0) begin errors++; $display("FAIL lb_disabled_bubble: got %b expected 0", bus2.out_valid); end
    rst = 1; #1; model_reset();
    finish_reset();
  endtask

  task automatic test_reset_mid_drain();
    bus.instr_valid = 1; bus.op = 4'b0111;
    advance();
    checks++; if (bus.halt_n !== 1'b0) begin errors++; $display("FAIL mid_drain_setup: got %b expected 0", bus.halt_n); end
    drive_idle();
    #2; rst = 1; #1; model_reset();
    checks++; if (act_word !== BUBBLE || bus.halted !== 1'b0 || bus.fsm_state !== 2'd0)
      begin errors++; $display("FAIL mid_drain_reset: got %h halted=%b st=%0d expected %h 0 0", act_word, bus.halted, bus.fsm_state, BUBBLE); end
    finish_reset();
    bus.instr_valid = 1; bus.op = 4'b1001;
    advance();
    checks++; if (bus.alu_func !== 4'b1001 || bus.alu_src !== 1'b1 || act_word !== m_word)
      begin errors++; $display("FAIL ori_after_reset: got %h expected %h", act_word, m_word); end
    drive_idle();
    advance();
  endtask

  task automatic test_random();
    logic [18:0] exp_w;
    for (int n = 0; n < 400; n++) begin
      bus.instr_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) bus.op = 4'($urandom_range(0, 15));
      else bus.op = DEF_OPS[$urandom_range(0, 10)];
      bus.funct = 4'($urandom_range(0, 15));
      bus.stall = ($urandom_range(0, 5) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      bus.ex_is_load = ($urandom_range(0, 1) == 1);
      bus.ex_rd = 4'($urandom_range(0, 3));
      bus.id_rs = 4'($urandom_range(0, 3));
      bus.id_rt = 4'($urandom_range(0, 3));
      #1;
      checks++; if (bus.hazard_stall !== model_hazard())
        begin errors++; $display("FAIL rand_hazard[%0d]: got %b expected %b", n, bus.hazard_stall, model_hazard()); end
      advance();
      exp_q.push_back(m_word);
      exp_w = exp_q.pop_front();
      checks++; if (act_word !== exp_w)
        begin errors++; $display("FAIL rand_word[%0d]: got %h expected %h", n, act_word, exp_w); end
      checks++; if (bus.halted !== model_halted())
        begin errors++; $display("FAIL rand_halted[%0d]: got %b expected %b", n, bus.halted, model_halted()); end
      if (model_halted()) begin
        rst = 1; #1; model_reset();
        finish_reset();
      end
    end
    drive_idle();
    rst = 1; #1; model_reset();
    finish_reset();
  endtask

  initial begin
    rst = 1;
    test_reset();
    test_decode_sweep();
    test_load_use();
    test_stall_flush();
    test_halt_drain();
    test_byte_disabled();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
